// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
//
// Main controller for the multi-cycle MIPS datapath (shared instruction/data
// memory, single ALU). Moore FSM sequencing fetch, decode, execute, memory and
// writeback, with a mem_req/mem_ready handshake toward memory.
//
// Build option: define MC_JUMP_EN to include the JUMP state (opcode 000010).
// Without it, opcode 000010 decodes as illegal and PCSrc never becomes 10.
//
// Handshake: mem_req is held high, together with IorD/MemWrite, from the
// first cycle of an access until the cycle in which mem_ready=1. That cycle
// completes the access and the FSM advances on the following edge. mem_ready
// is ignored in states that do not drive mem_req.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   Opcode, Funct         instruction register fields [31:26], [5:0]
//   zero_flag             ALU zero result (branch condition)
//   mem_ready             memory completes the current access this cycle
//   mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
//   ALUSrcA, ALUSrcB, ALU_Control, PCSrc, PCEn   datapath controls
//   instr_done            high in the final cycle of each instruction
//   illegal_op            high in a DECODE cycle with an unsupported opcode
//   state_o               current state encoding (debug)
// -----------------------------------------------------------------------------
module multicycle_control_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       zero_flag,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALU_Control,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECUTE  = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_ADDIEXEC = 4'd10,
    S_ADDIWB   = 4'd11,
    S_JUMP     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b110;
  localparam logic [2:0] ALU_MUL = 3'b101;

  state_t state_q, state_d;

  // Registered state-only outputs, computed from the next state so they are
  // valid for the whole cycle the FSM spends in that state.
  logic       mem_req_q, iord_q, memwrite_q, regdst_q, memtoreg_q, regwrite_q;
  logic       alusrca_q, pcen_q, done_q;
  logic [1:0] alusrcb_q, pcsrc_q;
  logic [2:0] aluctl_q;
  logic       mem_req_d, iord_d, memwrite_d, regdst_d, memtoreg_d, regwrite_d;
  logic       alusrca_d, pcen_d, done_d;
  logic [1:0] alusrcb_d, pcsrc_d;
  logic [2:0] aluctl_d;
  // One-hot state flags used for the input-gated (Mealy) terms.
  logic       fetch_q, decode_q, memwr_st_q, exec_q, branch_q;

  logic       op_legal;
  logic [2:0] funct_alu;

  always_comb begin
    op_legal = 1'b0;
    case (Opcode)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI: op_legal = 1'b1;
`ifdef MC_JUMP_EN
      OP_J:                                    op_legal = 1'b1;
`endif
      default:                                 op_legal = 1'b0;
    endcase
  end

  always_comb begin
    funct_alu = ALU_ADD;
    case (Funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b101010: funct_alu = ALU_SLT;
      6'b011100: funct_alu = ALU_MUL;
      default:   funct_alu = ALU_ADD;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     state_d = S_FETCH;
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
`ifdef MC_JUMP_EN
          OP_J:         state_d = S_JUMP;
`endif
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (Opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_ADDIEXEC: state_d = S_ADDIWB;
      S_ADDIWB:   state_d = S_FETCH;
`ifdef MC_JUMP_EN
      S_JUMP:     state_d = S_FETCH;
`endif
      default:    state_d = S_IDLE;
    endcase
  end

  // Moore output decode of the state being entered
  always_comb begin
    mem_req_d  = 1'b0;
    iord_d     = 1'b0;
    memwrite_d = 1'b0;
    regdst_d   = 1'b0;
    memtoreg_d = 1'b0;
    regwrite_d = 1'b0;
    alusrca_d  = 1'b0;
    alusrcb_d  = 2'b00;
    aluctl_d   = ALU_ADD;
    pcsrc_d    = 2'b00;
    pcen_d     = 1'b0;
    done_d     = 1'b0;
    case (state_d)
      S_IDLE:     aluctl_d = 3'b000;
      S_FETCH:    begin mem_req_d = 1'b1; alusrcb_d = 2'b01; end
      S_DECODE:   alusrcb_d = 2'b11;
      S_MEMADR:   begin alusrca_d = 1'b1; alusrcb_d = 2'b10; end
      S_MEMREAD:  begin mem_req_d = 1'b1; iord_d = 1'b1; end
      S_MEMWB:    begin regwrite_d = 1'b1; memtoreg_d = 1'b1; done_d = 1'b1; end
      S_MEMWRITE: begin mem_req_d = 1'b1; iord_d = 1'b1; memwrite_d = 1'b1; end
      S_EXECUTE:  alusrca_d = 1'b1;
      S_ALUWB:    begin regwrite_d = 1'b1; regdst_d = 1'b1; done_d = 1'b1; end
      S_BRANCH: begin
        alusrca_d = 1'b1;
        aluctl_d  = ALU_SUB;
        pcsrc_d   = 2'b01;
        done_d    = 1'b1;
      end
      S_ADDIEXEC: begin alusrca_d = 1'b1; alusrcb_d = 2'b10; end
      S_ADDIWB:   begin regwrite_d = 1'b1; done_d = 1'b1; end
`ifdef MC_JUMP_EN
      S_JUMP:     begin pcsrc_d = 2'b10; pcen_d = 1'b1; done_d = 1'b1; end
`endif
      default:    aluctl_d = 3'b000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mem_req_q  <= 1'b0;
      iord_q     <= 1'b0;
      memwrite_q <= 1'b0;
      regdst_q   <= 1'b0;
      memtoreg_q <= 1'b0;
      regwrite_q <= 1'b0;
      alusrca_q  <= 1'b0;
      alusrcb_q  <= 2'b00;
      aluctl_q   <= 3'b000;
      pcsrc_q    <= 2'b00;
      pcen_q     <= 1'b0;
      done_q     <= 1'b0;
      fetch_q    <= 1'b0;
      decode_q   <= 1'b0;
      memwr_st_q <= 1'b0;
      exec_q     <= 1'b0;
      branch_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      iord_q     <= iord_d;
      memwrite_q <= memwrite_d;
      regdst_q   <= regdst_d;
      memtoreg_q <= memtoreg_d;
      regwrite_q <= regwrite_d;
      alusrca_q  <= alusrca_d;
      alusrcb_q  <= alusrcb_d;
      aluctl_q   <= aluctl_d;
      pcsrc_q    <= pcsrc_d;
      pcen_q     <= pcen_d;
      done_q     <= done_d;
      fetch_q    <= (state_d == S_FETCH);
      decode_q   <= (state_d == S_DECODE);
      memwr_st_q <= (state_d == S_MEMWRITE);
      exec_q     <= (state_d == S_EXECUTE);
      branch_q   <= (state_d == S_BRANCH);
    end
  end

  assign mem_req     = mem_req_q;
  assign IorD        = iord_q;
  assign MemWrite    = memwrite_q;
  assign RegDst      = regdst_q;
  assign MemtoReg    = memtoreg_q;
  assign RegWrite    = regwrite_q;
  assign ALUSrcA     = alusrca_q;
  assign ALUSrcB     = alusrcb_q;
  assign PCSrc       = pcsrc_q;
  assign state_o     = state_q;
  // Funct is read live in EXECUTE: the instruction register holds it then.
  assign ALU_Control = exec_q ? funct_alu : aluctl_q;
  // Opcode is only valid once IR has loaded, so decode checks are live too.
  assign illegal_op  = decode_q & ~op_legal;
  assign IRWrite     = fetch_q & mem_ready;
  assign PCEn        = pcen_q | (fetch_q & mem_ready) | (branch_q & zero_flag);
  assign instr_done  = done_q | illegal_op | (memwr_st_q & mem_ready);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_fsm
//
// Directed bench for multicycle_control_fsm. Each step sets inputs, checks
// state_o and the packed output vector against hand-written constants, then
// advances one clock. Output vector bit order (MSB first):
//   mem_req IorD MemWrite IRWrite | RegDst MemtoReg RegWrite ALUSrcA |
//   ALUSrcB[1:0] | ALU_Control[2:0] | PCSrc[1:0] | PCEn instr_done illegal_op
// -----------------------------------------------------------------------------
module tb_multicycle_control_fsm;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  always #5 clk = ~clk;

  logic [5:0] Opcode, Funct;
  logic       zero_flag, mem_ready;
  logic       mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
  logic       ALUSrcA, PCEn, instr_done, illegal_op;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALU_Control;
  logic [3:0] state_o;

  multicycle_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Funct(Funct),
    .zero_flag(zero_flag), .mem_ready(mem_ready),
    .mem_req(mem_req), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALU_Control(ALU_Control),
    .PCSrc(PCSrc), .PCEn(PCEn), .instr_done(instr_done),
    .illegal_op(illegal_op), .state_o(state_o)
  );

  logic [17:0] outs;
  assign outs = {mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                 ALUSrcA, ALUSrcB, ALU_Control, PCSrc, PCEn, instr_done,
                 illegal_op};

  // Expected output vectors, per state / situation
  localparam logic [17:0] O_IDLE    = 18'b0000_0000_00_000_00_000;
  localparam logic [17:0] O_FETCHW  = 18'b1000_0000_01_010_00_000;
  localparam logic [17:0] O_FETCHR  = 18'b1001_0000_01_010_00_100;
  localparam logic [17:0] O_DECODE  = 18'b0000_0000_11_010_00_000;
  localparam logic [17:0] O_DECILL  = 18'b0000_0000_11_010_00_011;
  localparam logic [17:0] O_MEMADR  = 18'b0000_0001_10_010_00_000;
  localparam logic [17:0] O_MEMRD   = 18'b1100_0000_00_010_00_000;
  localparam logic [17:0] O_MEMWB   = 18'b0000_0110_00_010_00_010;
  localparam logic [17:0] O_MEMWRW  = 18'b1110_0000_00_010_00_000;
  localparam logic [17:0] O_MEMWRR  = 18'b1110_0000_00_010_00_010;
  localparam logic [17:0] O_EX_ADD  = 18'b0000_0001_00_010_00_000;
  localparam logic [17:0] O_EX_SUB  = 18'b0000_0001_00_100_00_000;
  localparam logic [17:0] O_EX_SLT  = 18'b0000_0001_00_110_00_000;
  localparam logic [17:0] O_EX_MUL  = 18'b0000_0001_00_101_00_000;
  localparam logic [17:0] O_ALUWB   = 18'b0000_1010_00_010_00_010;
  localparam logic [17:0] O_BR_T    = 18'b0000_0001_00_100_01_110;
  localparam logic [17:0] O_BR_N    = 18'b0000_0001_00_100_01_010;
  localparam logic [17:0] O_ADDIX   = 18'b0000_0001_10_010_00_000;
  localparam logic [17:0] O_ADDIWB  = 18'b0000_0010_00_010_00_010;
  localparam logic [17:0] O_JUMP    = 18'b0000_0000_00_010_10_110;

  int checks = 0;
  int errors = 0;

  // ---------------- checking / driver tasks ----------------
  task automatic chk(input string tag, input logic [17:0] obs,
                     input logic [17:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Settle, check state and outputs for the current cycle, then clock once.
  task automatic step(input string tag, input logic [3:0] st,
                      input logic [17:0] ov);
    #1;
    chk({tag, "_state"}, {14'd0, state_o}, {14'd0, st});
    chk({tag, "_outs"}, outs, ov);
    @(posedge clk);
    #1;
  endtask

  // FETCH with zero wait states, leaves the FSM in DECODE.
  task automatic fetch(input string tag);
    mem_ready = 1'b1;
    step(tag, 4'd1, O_FETCHR);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0; Opcode = 6'd0; Funct = 6'd0; zero_flag = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    #1;
    chk("reset_state", {14'd0, state_o}, 18'd0);
    chk("reset_outs", outs, O_IDLE);

    // Release mid-cycle; first edge moves to FETCH.
    rst_n = 1'b1;
    mem_ready = 1'b1;
    step("idle", 4'd0, O_IDLE);
    // One FETCH wait state first
    mem_ready = 1'b0;
    step("fetch_wait", 4'd1, O_FETCHW);
    fetch("fetch0");

    // lw with two MEMREAD wait states: 2,3,4,4,4,5
    Opcode = 6'b100011; mem_ready = 1'b0;
    step("lw_dec", 4'd2, O_DECODE);
    step("lw_adr", 4'd3, O_MEMADR);
    step("lw_rd0", 4'd4, O_MEMRD);
    step("lw_rd1", 4'd4, O_MEMRD);
    mem_ready = 1'b1;
    step("lw_rd2", 4'd4, O_MEMRD);
    mem_ready = 1'b0;
    step("lw_wb", 4'd5, O_MEMWB);
    fetch("fetch1");

    // R-type slt
    Opcode = 6'b000000; Funct = 6'b101010;
    step("slt_dec", 4'd2, O_DECODE);
    step("slt_ex", 4'd7, O_EX_SLT);
    step("slt_wb", 4'd8, O_ALUWB);
    fetch("fetch2");
    // R-type unknown funct -> add
    Funct = 6'b111111;
    step("unk_dec", 4'd2, O_DECODE);
    step("unk_ex", 4'd7, O_EX_ADD);
    step("unk_wb", 4'd8, O_ALUWB);
    fetch("fetch3");
    // R-type sub and mul
    Funct = 6'b100010;
    step("sub_dec", 4'd2, O_DECODE);
    step("sub_ex", 4'd7, O_EX_SUB);
    step("sub_wb", 4'd8, O_ALUWB);
    fetch("fetch4");
    Funct = 6'b011100;
    step("mul_dec", 4'd2, O_DECODE);
    step("mul_ex", 4'd7, O_EX_MUL);
    step("mul_wb", 4'd8, O_ALUWB);
    fetch("fetch5");

    // beq taken / not taken
    Opcode = 6'b000100; zero_flag = 1'b1;
    step("beqt_dec", 4'd2, O_DECODE);
    step("beqt_br", 4'd9, O_BR_T);
    fetch("fetch6");
    zero_flag = 1'b0;
    step("beqn_dec", 4'd2, O_DECODE);
    step("beqn_br", 4'd9, O_BR_N);
    fetch("fetch7");

    // sw with three MEMWRITE wait states
    Opcode = 6'b101011; mem_ready = 1'b0;
    step("sw_dec", 4'd2, O_DECODE);
    step("sw_adr", 4'd3, O_MEMADR);
    step("sw_w0", 4'd6, O_MEMWRW);
    step("sw_w1", 4'd6, O_MEMWRW);
    step("sw_w2", 4'd6, O_MEMWRW);
    mem_ready = 1'b1;
    step("sw_w3", 4'd6, O_MEMWRR);
    fetch("fetch8");

    // addi
    Opcode = 6'b001000;
    step("addi_dec", 4'd2, O_DECODE);
    step("addi_ex", 4'd10, O_ADDIX);
    step("addi_wb", 4'd11, O_ADDIWB);
    fetch("fetch9");

    // illegal opcode
    Opcode = 6'b111111;
    step("ill_dec", 4'd2, O_DECILL);
    fetch("fetch10");

    // jump (illegal when the JUMP state is not built)
    Opcode = 6'b000010;
`ifdef MC_JUMP_EN
    step("j_dec", 4'd2, O_DECODE);
    step("j_jump", 4'd12, O_JUMP);
`else
    step("j_dec", 4'd2, O_DECILL);
`endif
    fetch("fetch11");

    // Reset asserted in the middle of a MEMREAD wait
    Opcode = 6'b100011; mem_ready = 1'b0;
    step("lw2_dec", 4'd2, O_DECODE);
    step("lw2_adr", 4'd3, O_MEMADR);
    step("lw2_rd", 4'd4, O_MEMRD);
    rst_n = 1'b0;
    #1;
    chk("midrst_state", {14'd0, state_o}, 18'd0);
    chk("midrst_outs", outs, O_IDLE);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    step("rst_idle", 4'd0, O_IDLE);
    fetch("fetch12");
    mem_ready = 1'b0;
    step("rst_dec", 4'd2, O_DECODE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Main controller for the multi-cycle MIPS datapath, which uses a shared instruction/data memory and a single ALU. The block is a Moore state machine with a memory ready/request handshake. It sequences each instruction through fetch, decode, execute, memory and writeback, and drives every datapath mux, enable and the 3-bit ALU control. It uses the same ALU control encoding as the single-cycle control unit.

## Interface
No parameters.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- Opcode  input  6  instruction register bits [31:26]; stable from DECODE onward
- Funct  input  6  instruction register bits [5:0]
- zero_flag  input  1  ALU zero result
- mem_ready  input  1  memory has completed the current access this cycle
- mem_req  output  1  memory access request
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  instruction register load
- RegDst  output  1  register destination select: 1 = rd, 0 = rt
- MemtoReg  output  1  writeback data select: 1 = Data register
- RegWrite  output  1  register file write
- ALUSrcA  output  1  ALU A select: 0 = PC, 1 = register A
- ALUSrcB  output  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- ALU_Control  output  3  ALU operation: 010 add, 100 sub, 110 slt, 101 mul
- PCSrc  output  2  PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- PCEn  output  1  PC load enable
- instr_done  output  1  high in the final cycle of each instruction
- illegal_op  output  1  high in a DECODE cycle with an unsupported opcode
- state_o  output  4  current state encoding, for debug

## Operation
- State encodings: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMREAD 4, MEMWB 5, MEMWRITE 6, EXECUTE 7, ALUWB 8, BRANCH 9, ADDIEXEC 10, ADDIWB 11, JUMP 12. Codes 13–15 go to IDLE.
- Default for every output is 0, with ALU_Control = 010. Each state lists only the outputs it changes.
- IDLE: all outputs 0. Next state FETCH.
- FETCH: mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01.
  - Stays in FETCH while mem_ready=0.
  - In the cycle mem_ready=1: IRWrite=1 and PCEn=1 (PCSrc=00), then next state DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11 (computes the branch target). Next state by opcode:
  - 100011 or 101011 → MEMADR
  - 000000 → EXECUTE
  - 000100 → BRANCH
  - 001000 → ADDIEXEC
  - 000010 → JUMP
  - any other opcode → FETCH, with illegal_op=1 and instr_done=1
- MEMADR: ALUSrcA=1, ALUSrcB=10. Next state MEMREAD if Opcode=100011, otherwise MEMWRITE.
- MEMREAD: mem_req=1, IorD=1. Stays until mem_ready=1, then MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1. Next state FETCH.
- MEMWRITE: mem_req=1, IorD=1, MemWrite=1, all held through wait cycles. On mem_ready=1: instr_done=1, next state FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00. ALU_Control from Funct:
  - 100000 → 010
  - 100010 → 100
  - 101010 → 110
  - 011100 → 101
  - any other value → 010
  - Next state ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALU_Control=100, PCSrc=01, PCEn=zero_flag, instr_done=1. Next state FETCH.
- ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALU_Control=010. Next state ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1. Next state FETCH.
- JUMP: PCSrc=10, PCEn=1, instr_done=1. Next state FETCH.
- Output classes:
  - Pure functions of state (Moore): all outputs except those listed below.
  - Gated by mem_ready (Mealy): IRWrite, PCEn in FETCH, and instr_done in MEMWRITE.
  - Gated by zero_flag: PCEn in BRANCH.

## Timing
- Reset:
  - Asserting rst_n=0 forces state IDLE immediately, in any state, including mid-handshake. All outputs go to 0 and mem_req drops without waiting for mem_ready.
  - After rst_n rises, the first clock edge moves IDLE → FETCH. mem_req first goes high one cycle after deassertion.
- Cycles per instruction with zero wait states (mem_ready=1 on first request):
  - lw: 5
  - sw: 4
  - R-type: 4
  - addi: 4
  - beq: 3
  - j: 3
  - illegal opcode: 2
- Memory wait states: each cycle with mem_ready=0 adds one cycle in FETCH, MEMREAD or MEMWRITE. While waiting, address and data controls hold constant.
- mem_ready is ignored in every state that does not drive mem_req.

## Configuration
- MC_JUMP_EN defined: the JUMP state exists, and opcode 000010 decodes to JUMP.
- MC_JUMP_EN undefined: there is no JUMP state. Opcode 000010 is treated as illegal (illegal_op=1, return to FETCH), and PCSrc never takes the value 10.

## Test plan
- Reset and fetch: assert rst_n=0 mid-MEMREAD → state_o=0 and all outputs 0 in the same cycle. Release with mem_ready=1 → FETCH, then DECODE; IRWrite and PCEn each pulse exactly once.
- lw with wait states: Opcode=100011, mem_ready low for 2 cycles in MEMREAD → states 1,2,3,4,4,4,5. RegWrite=1 and MemtoReg=1 only in state 5. instr_done pulses once. Total 7 cycles.
- R-type: Funct=101010 → ALU_Control=110 in EXECUTE, then ALUWB with RegDst=1. Funct=111111 → ALU_Control=010.
- beq: zero_flag=1 → PCEn=1 with PCSrc=01 in BRANCH. zero_flag=0 → PCEn=0. Both return to FETCH after 3 cycles.
- sw hold: Opcode=101011, mem_ready=0 for 3 cycles → MemWrite, IorD and mem_req held at 1 for 4 cycles, and RegWrite stays 0 throughout.
- Jump and illegal opcode: Opcode=000010 with MC_JUMP_EN defined → JUMP state with PCSrc=10 and PCEn=1. Without MC_JUMP_EN, and for Opcode=111111 → illegal_op=1 for one cycle in DECODE, next state FETCH, no RegWrite or MemWrite asserted.
